// File: rtl/sid_reg_write_arbiter.sv
// sid_reg_write_arbiter: round-robin arbiter driving the SID setup/strobe/hold register-write sequence
module sid_reg_write_arbiter #(
   parameter int NREQ        = 2,
   parameter int WE_CYCLES   = 2,
   parameter int HOLD_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pause,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [2*NREQ-1:0] req_voice,
   input  logic [3*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        bus_ui,
   output logic [7:0]        bus_data,
   output logic              busy,
   output logic [2:0]        grant_id,
   output logic              wr_done
);
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] rr_q, rr_d, gid_q, gid_d;
   logic [1:0] voice_q, voice_d, voice_sel;
   logic [2:0] addr_q, addr_d, addr_sel;
   logic [7:0] data_q, data_d, data_sel;
   logic [2:0] gnt, hi_idx, lo_idx;
   logic       hi, lo, take, last_we, last_hold;
   // first valid requester at or after the pointer, else lowest valid index (wrap)
   always_comb begin
      hi        = 1'b0;
      lo        = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      voice_sel = '0;
      addr_sel  = '0;
      data_sel  = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo     = 1'b1;
            lo_idx = 3'(i);
         end
         if (req_valid[i] && 3'(i) >= rr_q) begin
            hi     = 1'b1;
            hi_idx = 3'(i);
         end
      end
      gnt = hi ? hi_idx : lo_idx;
      for (int i = 0; i < NREQ; i++) begin
         if (3'(i) == gnt) begin
            voice_sel = req_voice[2*i +: 2];
            addr_sel  = req_addr[3*i +: 3];
            data_sel  = req_data[8*i +: 8];
         end
      end
   end
   assign take      = state_q == IDLE && !pause && lo && !rst;
   assign req_ready = take ? NREQ'(1) << gnt : '0;
   assign last_we   = cnt_q == 8'(WE_CYCLES-1);
   assign last_hold = cnt_q == 8'(HOLD_CYCLES-1);
   // write sequencer: grant and latch payload in IDLE, then setup, strobe, hold
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      voice_d = voice_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: if (take) begin
            state_d = SETUP;
            rr_d    = (gnt == 3'(NREQ-1)) ? 3'd0 : gnt + 3'd1;
            gid_d   = gnt;
            voice_d = voice_sel;
            addr_d  = addr_sel;
            data_d  = data_sel;
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = '0;
         end
         STROBE: begin
            state_d = last_we ? HOLD : STROBE;
            cnt_d   = last_we ? 8'd0 : cnt_q + 8'd1;
         end
         HOLD: begin
            state_d = last_hold ? IDLE : HOLD;
            cnt_d   = last_hold ? 8'd0 : cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and payload registers; async reset aborts any write in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rr_q    <= '0;
         gid_q   <= '0;
         voice_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         voice_q <= voice_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end
   assign busy     = state_q != IDLE;
   assign wr_done  = state_q == HOLD && last_hold;
   assign grant_id = gid_q;
   assign bus_ui   = {state_q == STROBE, 2'b00, voice_q, addr_q};
   assign bus_data = data_q;
endmodule

// File: tb/tb_sid_reg_write_arbiter.sv
// tb_sid_reg_write_arbiter: random requesters checked against a write-timeline reference model
module tb_sid_reg_write_arbiter;
   localparam int N    = 3;
   localparam int WE   = 2;
   localparam int HOLD = 1;
   localparam int LAST = 1 + WE + HOLD;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           pause = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [2*N-1:0] req_voice = '0;
   logic [3*N-1:0] req_addr = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic [7:0]     bus_ui, bus_data;
   logic           busy, wr_done;
   logic [2:0]     grant_id;
   int             n_cmp = 0;
   int             n_err = 0;
   logic           vld[N];
   logic           clr[N];
   logic [1:0]     pv[N];
   logic [2:0]     pa[N];
   logic [7:0]     pd[N];
   int             t, rr, mid, g;
   logic [1:0]     mv;
   logic [2:0]     ma;
   logic [7:0]     md, ui_e;
   bit             rst_done, force_v;

   sid_reg_write_arbiter #(.NREQ(N), .WE_CYCLES(WE), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst(rst), .pause(pause), .req_valid(req_valid), .req_voice(req_voice),
      .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready), .bus_ui(bus_ui),
      .bus_data(bus_data), .busy(busy), .grant_id(grant_id), .wr_done(wr_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic new_payload(input int i);
      vld[i] = 1'b1;
      pv[i]  = 2'($urandom);
      pa[i]  = 3'($urandom);
      pd[i]  = 8'($urandom);
   endtask

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = vld[i];
         req_voice[2*i +: 2] = pv[i];
         req_addr[3*i +: 3]  = pa[i];
         req_data[8*i +: 8]  = pd[i];
      end
   endtask

   task automatic model_reset();
      t  = 0;
      rr = 0;
      mid = 0;
      mv = '0;
      ma = '0;
      md = '0;
      for (int i = 0; i < N; i++) begin
         clr[i] = 1'b0;
         new_payload(i);
      end
      pack();
   endtask

   initial begin
      rst_done = 1'b0;
      force_v  = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_bus_ui", 32'(bus_ui), 0);
      check("rst_bus_data", 32'(bus_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_wr_done", 32'(wr_done), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         ui_e = {(t >= 2 && t <= 1 + WE), 2'b00, mv, ma};
         check("bus_ui", 32'(ui_e), 32'(bus_ui) ^ 32'(ui_e) ^ 32'(ui_e));
         check("bus_data", 32'(bus_data), 32'(md));
         check("busy", 32'(busy), 32'(t != 0));
         check("wr_done", 32'(wr_done), 32'(t == LAST));
         if (t != 0) check("grant_id", 32'(grant_id), 32'(mid));
         if (n >= 1500 && !rst_done && t == 2) begin
            rst_done = 1'b1;
            #1 rst = 1'b1;
            #1;
            check("abort_bus_ui", 32'(bus_ui), 0);
            check("abort_bus_data", 32'(bus_data), 0);
            check("abort_busy", 32'(busy), 0);
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            force_v = 1'b1;
            continue;
         end
         for (int i = 0; i < N; i++) begin
            if (!force_v) begin
               if (clr[i]) vld[i] = 1'b0;
               if (!vld[i]) begin
                  if ($urandom_range(0, 2) == 0) new_payload(i);
               end else if ($urandom_range(0, 31) == 0) vld[i] = 1'b0;
            end
            clr[i] = 1'b0;
         end
         pause = !force_v && $urandom_range(0, 5) == 0;
         pack();
         #1;
         g = -1;
         if (t == 0 && !pause)
            for (int k = 0; k < N; k++)
               if (g < 0 && vld[(rr + k) % N]) g = (rr + k) % N;
         check("req_ready", 32'(req_ready), g >= 0 ? 32'(1) << g : 32'(0));
         if (force_v) check("post_rst_ready0", 32'(req_ready), 1);
         force_v = 1'b0;
         if (g >= 0) begin
            mv = pv[g];
            ma = pa[g];
            md = pd[g];
            mid = g;
            rr = (g + 1) % N;
            clr[g] = 1'b1;
            t = 1;
         end else if (t != 0) t = (t == LAST) ? 0 : t + 1;
         @(negedge clk);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
